aes_top: RTL and testbench
==========================

// Module: aes_top
// PURPOSE
//  Self-contained AES-128 encryption core for on-board bring-up. No data inputs:
//  it encrypts a built-in plaintext under a built-in key once after reset, one
//  round per clock, and drives the 128-bit result on out. debug_mode exposes the
//  round-by-round state so the datapath can be inspected in simulation/ILA.
// PARAMETERS
//  PLAINTEXT  128'h00112233445566778899aabbccddeeff  block to encrypt (byte 0 = MSB)
//  KEY        128'h000102030405060708090a0b0c0d0e0f  AES-128 cipher key
// PORTS
//  clk         in   1        rising-edge clock, sole clock
//  rst         in   1        synchronous, active-high reset
//  debug_mode  in   1        1: out shows live state; 0: out shows final result only
//  out         out  [0:127]  result/state; out[0:7] = byte 0 (FIPS-197 byte order)
// BEHAVIOUR
//  - Registers: state[0:127], rkey[0:127] (current round key), round[3:0], done.
//  - rst=1 at an edge: state=0, rkey=0, round=0, done=0 (so out=0 in both modes).
//  - Edge 1 after rst low (round==0): state <= PLAINTEXT ^ KEY; rkey <= KEY; round <= 1.
//  - Edges 2..10 (round 1..9): state <= MixColumns(ShiftRows(SubBytes(state))) ^ nextkey;
//    rkey <= nextkey; round++.
//  - Edge 11 (round 10): final round without MixColumns; done <= 1; round <= 11.
//  - round==11: all registers hold until next reset (one-shot; no restart).
//  - nextkey = standard AES-128 key-schedule step from rkey using Rcon[round]
//    (01,02,04,08,10,20,40,80,1b,36); expanded on the fly, no key RAM.
//  - SubBytes: FIPS-197 S-box (16 parallel instances + 4 for key schedule),
//    combinational; MixColumns in GF(2^8) with poly 0x11b (xtime).
//  - out (combinational mux on registers): debug_mode=1 -> state;
//    debug_mode=0 -> done ? state : 128'h0. debug_mode may toggle any cycle;
//    it never affects the computation.
//  - Latency: ciphertext valid on out after 11 rising edges with rst low.
//  - rst asserted mid-operation: abort at that edge, return to reset values,
//    restart from edge 1 on release. rst held high: outputs stay 0.
// TESTING
//  1 rst high 3 cycles, debug_mode=0/1 -> out=0 throughout.
//  2 release rst, debug_mode=1 -> after edge 1 out=00102030405060708090a0b0c0d0e0f0;
//    after edge 2 out=89d810e8855ace682d1843d8cb128fe4.
//  3 debug_mode=0 -> out=0 for edges 1..10; after edge 11
//    out=69c4e0d86a7b0430d8cdb78070b4c55a and holds 20+ further cycles.
//  4 override KEY=2b7e151628aed2a6abf7158809cf4f3c, PLAINTEXT=3243f6a8885a308d313198a2e0370734
//    -> after edge 11 out=3925841d02dc09fbdc118597196a0b32.
//  5 assert rst at edge 5 for 1 cycle, then release -> out=0 during reset;
//    ciphertext appears exactly 11 edges after release.
//  6 toggle debug_mode every cycle -> final value identical to scenario 3;
//    out=0 whenever debug_mode=0 and done=0.

Source files
------------

// File: rtl/aes_top.sv
// AES-128 one-shot bring-up core: encrypts a built-in block under a built-in key
// after reset, one round per clock; debug_mode exposes the per-round state.
module aes_top #(
  parameter logic [127:0] PLAINTEXT = 128'h00112233445566778899aabbccddeeff,
  parameter logic [127:0] KEY       = 128'h000102030405060708090a0b0c0d0e0f
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         debug_mode,
  output logic [0:127] out
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic [7:0]   sb_b [16];
  logic [7:0]   sr_b [16];
  logic [7:0]   mc_b [16];
  logic [127:0] sr_w, mc_w, nextkey;
  logic [31:0]  ks_t, nk0, nk1, nk2, nk3;

  // Internal vectors keep byte 0 in bits [127:120]; the [0:127] port maps it to out[0:7].
  always_comb begin
    sr_w = '0;
    mc_w = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sb_b[i] = sbox(state_q[127-8*i -: 8]);
    end
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr_b[r + 4*c] = sb_b[r + 4*((c + r) % 4)];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mc_b[4*c]   = xtime(sr_b[4*c]) ^ xtime(sr_b[4*c+1]) ^ sr_b[4*c+1] ^ sr_b[4*c+2] ^ sr_b[4*c+3];
      mc_b[4*c+1] = sr_b[4*c] ^ xtime(sr_b[4*c+1]) ^ xtime(sr_b[4*c+2]) ^ sr_b[4*c+2] ^ sr_b[4*c+3];
      mc_b[4*c+2] = sr_b[4*c] ^ sr_b[4*c+1] ^ xtime(sr_b[4*c+2]) ^ xtime(sr_b[4*c+3]) ^ sr_b[4*c+3];
      mc_b[4*c+3] = xtime(sr_b[4*c]) ^ sr_b[4*c] ^ sr_b[4*c+1] ^ sr_b[4*c+2] ^ xtime(sr_b[4*c+3]);
    end
    for (int unsigned i = 0; i < 16; i++) begin
      sr_w[127-8*i -: 8] = sr_b[i];
      mc_w[127-8*i -: 8] = mc_b[i];
    end
  end

  // On-the-fly key expansion: RotWord/SubWord on the last word, Rcon indexed by round.
  always_comb begin
    ks_t = {sbox(rkey_q[23:16]), sbox(rkey_q[15:8]), sbox(rkey_q[7:0]), sbox(rkey_q[31:24])}
           ^ {rcon(round_q), 24'h000000};
    nk0 = rkey_q[127:96] ^ ks_t;
    nk1 = rkey_q[95:64]  ^ nk0;
    nk2 = rkey_q[63:32]  ^ nk1;
    nk3 = rkey_q[31:0]   ^ nk2;
    nextkey = {nk0, nk1, nk2, nk3};
  end

  always_comb begin
    state_d = state_q;
    rkey_d  = rkey_q;
    round_d = round_q;
    done_d  = done_q;
    if (round_q == 4'd0) begin
      state_d = PLAINTEXT ^ KEY;
      rkey_d  = KEY;
      round_d = 4'd1;
    end else if (round_q <= 4'd10) begin
      state_d = ((round_q == 4'd10) ? sr_w : mc_w) ^ nextkey;
      rkey_d  = nextkey;
      round_d = round_q + 4'd1;
      done_d  = (round_q == 4'd10);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      rkey_q  <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rkey_q  <= rkey_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign out = (debug_mode || done_q) ? state_q : '0;

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: directed known-answer scenarios plus randomized
// reset/debug_mode traffic against a behavioural AES-128 model.
module tb_aes_top;

  logic         clk;
  logic         rst;
  logic         debug_mode;
  logic [0:127] out_a;
  logic [0:127] out_b;

  aes_top dut_a (
    .clk        (clk),
    .rst        (rst),
    .debug_mode (debug_mode),
    .out        (out_a)
  );

  aes_top #(
    .PLAINTEXT (128'h3243f6a8885a308d313198a2e0370734),
    .KEY       (128'h2b7e151628aed2a6abf7158809cf4f3c)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .debug_mode (debug_mode),
    .out        (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_edges = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rs [2][11];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [7:0] v = b;
    for (int i = 0; i < k; i++) v = {v[6:0], v[7]};
    return v;
  endfunction

  // S-box from first principles: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_vectors(input int which, input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [7:0]   w [44][4];
    logic [7:0]   tmp [4];
    logic [7:0]   rc;
    logic [127:0] packed_s;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
      w[i/4][i%4] = key[127-8*i -: 8];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        logic [7:0] t0;
        t0 = tmp[0];
        tmp[0] = sbox_m[tmp[1]] ^ rc;
        tmp[1] = sbox_m[tmp[2]];
        tmp[2] = sbox_m[tmp[3]];
        tmp[3] = sbox_m[t0];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) packed_s[127-8*i -: 8] = s[i];
    exp_rs[which][0] = packed_s;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 4; k++) a[k] = s[4*c + k];
          for (int k = 0; k < 4; k++)
            s[4*c + k] = gmul(8'h02, a[k]) ^ gmul(8'h03, a[(k+1)%4]) ^ a[(k+2)%4] ^ a[(k+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][i%4];
      for (int i = 0; i < 16; i++) packed_s[127-8*i -: 8] = s[i];
      exp_rs[which][rnd] = packed_s;
    end
  endtask

  function automatic logic [127:0] model_out(input int which);
    logic [127:0] st;
    st = (n_edges == 0) ? 128'h0 : exp_rs[which][n_edges-1];
    return (debug_mode || n_edges == 11) ? st : 128'h0;
  endfunction

  // One rising edge; the model follows the rst value seen at that edge.
  task automatic step();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    if (r) n_edges = 0;
    else if (n_edges < 11) n_edges++;
    check_eq("model_a", out_a, model_out(0));
    check_eq("model_b", out_b, model_out(1));
  endtask

  initial begin
    rst = 1'b1;
    debug_mode = 1'b0;
    build_sbox();
    build_vectors(0, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
    build_vectors(1, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // held reset, both debug modes
    for (int i = 0; i < 3; i++) begin
      debug_mode = i[0];
      step();
      check_eq("reset_zero", out_a, 128'h0);
    end

    // live state after the first two rounds
    rst = 1'b0;
    debug_mode = 1'b1;
    step();
    check_eq("edge1_state", out_a, 128'h00102030405060708090a0b0c0d0e0f0);
    step();
    check_eq("edge2_state", out_a, 128'h89d810e8855ace682d1843d8cb128fe4);

    // final-only mode: hidden until edge 11, then held
    rst = 1'b1;
    step();
    rst = 1'b0;
    debug_mode = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      check_eq("hidden_before_done", out_a, 128'h0);
    end
    step();
    check_eq("ciphertext_a", out_a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check_eq("ciphertext_b", out_b, 128'h3925841d02dc09fbdc118597196a0b32);
    for (int i = 0; i < 20; i++) step();
    check_eq("ciphertext_hold", out_a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    debug_mode = 1'b1;
    #1;
    check_eq("hold_debug", out_a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // abort mid-operation at edge 5
    rst = 1'b1;
    step();
    rst = 1'b0;
    debug_mode = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    debug_mode = 1'b1;
    step();
    check_eq("abort_zero", out_a, 128'h0);
    rst = 1'b0;
    debug_mode = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_eq("abort_not_early", out_a, 128'h0);
    step();
    check_eq("abort_ciphertext", out_a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // debug_mode toggling every cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      debug_mode = ~debug_mode;
      step();
    end
    debug_mode = 1'b0;
    #1;
    check_eq("toggle_ciphertext", out_a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check_eq("toggle_ciphertext_b", out_b, 128'h3925841d02dc09fbdc118597196a0b32);

    // random reset pulses and debug_mode traffic
    for (int i = 0; i < 400; i++) begin
      debug_mode = 1'($urandom_range(0, 1));
      if (rst) rst = ($urandom_range(0, 2) == 0);
      else     rst = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
